// File: rtl/peripheral_spram_axi4_slave_if.sv
// AXI4 bus bundle between a burst master and the single-port RAM slave.
// The master drives requests, write data and response readies; the slave drives the rest.
interface peripheral_spram_axi4_slave_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/peripheral_spram_axi4_slave.sv
// AXI4 burst slave over a single-port RAM: FIXED/INCR/WRAP, byte strobes, SLVERR,
// one transaction at a time with alternating read/write priority on collisions.
module peripheral_spram_axi4_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                          aclk,
  input  logic                          areset,
  peripheral_spram_axi4_slave_if.slave  axi
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = ADDR_WIDTH - LB;

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [1:0]            burst;
  } req_t;

  state_t                state;
  req_t                  req;
  logic [7:0]            cnt;
  logic                  err, prio_rd;
  logic                  ram_v, ram_oob, ram_last, iss_done;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] incr, wmask, addr_nxt;
  logic [WW-1:0]         widx;
  logic                  oob, last_beat, beat_err, we, rd_issue, out_adv;

  // Reserved burst type, or WRAP with a length that has no power-of-two boundary.
  function automatic logic bad_burst(input logic [1:0] b, input logic [7:0] l);
    return (b == 2'd3) || (b == 2'd2 && !(l inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  always_comb begin
    incr  = req.addr + ADDR_WIDTH'(NB);
    wmask = ((ADDR_WIDTH'(req.len) + ADDR_WIDTH'(1)) << LB) - ADDR_WIDTH'(1);
    case (req.burst)
      2'd0:    addr_nxt = req.addr;
      2'd2:    addr_nxt = bad_burst(req.burst, req.len) ? incr
                          : ((req.addr & ~wmask) | (incr & wmask));
      default: addr_nxt = incr;
    endcase
  end

  assign widx      = req.addr[ADDR_WIDTH-1:LB];
  assign oob       = widx >= WW'(DEPTH);
  assign last_beat = cnt == req.len;
  assign beat_err  = (axi.wlast != last_beat) || oob;
  assign we        = (state == WRITE) && axi.wvalid && axi.wready && !oob && !areset;
  assign out_adv   = !axi.rvalid || axi.rready;
  // Fetch a beat when the RAM stage is empty or drains into the output register this cycle.
  assign rd_issue  = (state == READ) && !iss_done && (!ram_v || out_adv);

  always_ff @(posedge aclk) begin
    if (we)
      for (int b = 0; b < NB; b++)
        if (axi.wstrb[b]) mem[widx[IW-1:0]][8*b +: 8] <= axi.wdata[8*b +: 8];
    if (rd_issue) ram_q <= mem[widx[IW-1:0]];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= IDLE;
      req         <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      prio_rd     <= 1'b0;
      ram_v       <= 1'b0;
      ram_oob     <= 1'b0;
      ram_last    <= 1'b0;
      iss_done    <= 1'b0;
      axi.awready <= 1'b0;
      axi.arready <= 1'b0;
      axi.wready  <= 1'b0;
      axi.bvalid  <= 1'b0;
      axi.bresp   <= 2'd0;
      axi.bid     <= '0;
      axi.rvalid  <= 1'b0;
      axi.rresp   <= 2'd0;
      axi.rlast   <= 1'b0;
      axi.rid     <= '0;
      axi.rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (axi.awready) begin
            axi.awready <= 1'b0;
            if (axi.awvalid) begin
              req        <= '{id: axi.awid, addr: axi.awaddr, len: axi.awlen, burst: axi.awburst};
              cnt        <= '0;
              err        <= bad_burst(axi.awburst, axi.awlen);
              prio_rd    <= 1'b1;
              axi.wready <= 1'b1;
              state      <= WRITE;
            end
          end else if (axi.arready) begin
            axi.arready <= 1'b0;
            if (axi.arvalid) begin
              req      <= '{id: axi.arid, addr: axi.araddr, len: axi.arlen, burst: axi.arburst};
              cnt      <= '0;
              err      <= bad_burst(axi.arburst, axi.arlen);
              prio_rd  <= 1'b0;
              iss_done <= 1'b0;
              ram_v    <= 1'b0;
              state    <= READ;
            end
          end else if (axi.awvalid && (!axi.arvalid || !prio_rd)) begin
            axi.awready <= 1'b1;
          end else if (axi.arvalid) begin
            axi.arready <= 1'b1;
          end
        end
        WRITE: begin
          // Beat count alone ends the burst; a misplaced wlast only flags the error.
          if (axi.wvalid) begin
            if (last_beat) begin
              axi.wready <= 1'b0;
              axi.bvalid <= 1'b1;
              axi.bid    <= req.id;
              axi.bresp  <= (err || beat_err) ? 2'd2 : 2'd0;
              state      <= WRESP;
            end else begin
              cnt      <= cnt + 8'd1;
              req.addr <= addr_nxt;
              err      <= err || beat_err;
            end
          end
        end
        WRESP: begin
          if (axi.bready) begin
            axi.bvalid <= 1'b0;
            axi.bresp  <= 2'd0;
            state      <= IDLE;
          end
        end
        READ: begin
          if (rd_issue) begin
            ram_v    <= 1'b1;
            ram_oob  <= oob;
            ram_last <= last_beat;
            if (last_beat) iss_done <= 1'b1;
            else begin
              cnt      <= cnt + 8'd1;
              req.addr <= addr_nxt;
            end
          end else if (out_adv) begin
            ram_v <= 1'b0;
          end
          if (out_adv) begin
            axi.rvalid <= ram_v;
            if (ram_v) begin
              axi.rdata <= ram_oob ? '0 : ram_q;
              axi.rresp <= (ram_oob || err) ? 2'd2 : 2'd0;
              axi.rlast <= ram_last;
              axi.rid   <= req.id;
            end
          end
          if (axi.rvalid && axi.rready && axi.rlast) begin
            axi.rvalid <= 1'b0;
            axi.rlast  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_peripheral_spram_axi4_slave.sv
// Directed bench for the AXI4 SPRAM slave; expected B/R responses are queued at issue
// time and a negedge monitor pops and compares them as the slave presents them.
module tb_peripheral_spram_axi4_slave;
  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  peripheral_spram_axi4_slave_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  peripheral_spram_axi4_slave #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256)) dut (
    .aclk(aclk), .areset(areset), .axi(axi)
  );

  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;

  bexp_t       bq[$];
  rexp_t       rq[$];
  int          checks = 0;
  int          errors = 0;
  int          rmode  = 0;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] ed [16];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // rready: 0 = always high, 1 = alternating, 2 = held low
  initial begin
    axi.rready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      case (rmode)
        1:       axi.rready = ~axi.rready;
        2:       axi.rready = 1'b0;
        default: axi.rready = 1'b1;
      endcase
    end
  end

  initial begin
    bexp_t       b;
    rexp_t       r;
    logic        h_stall;
    logic [31:0] h_data;
    logic [1:0]  h_resp;
    logic        h_last;
    h_stall = 1'b0;
    forever begin
      @(negedge aclk);
      if (areset) h_stall = 1'b0;
      else begin
        if (axi.bvalid && axi.bready) begin
          if (bq.size() == 0) check("b_unexpected", bq.size(), 1);
          else begin
            b = bq.pop_front();
            check("bid", axi.bid, b.id);
            check("bresp", axi.bresp, b.resp);
          end
        end
        if (axi.rvalid) begin
          if (h_stall) begin
            check("rdata_stable", axi.rdata, h_data);
            check("rresp_stable", axi.rresp, h_resp);
            check("rlast_stable", axi.rlast, h_last);
          end
          if (axi.rready) begin
            h_stall = 1'b0;
            if (rq.size() == 0) check("r_unexpected", rq.size(), 1);
            else begin
              r = rq.pop_front();
              check("rid", axi.rid, r.id);
              check("rdata", axi.rdata, r.data);
              check("rresp", axi.rresp, r.resp);
              check("rlast", axi.rlast, r.last);
            end
          end else begin
            h_stall = 1'b1;
            h_data  = axi.rdata;
            h_resp  = axi.rresp;
            h_last  = axi.rlast;
          end
        end else h_stall = 1'b0;
      end
    end
  end

  function automatic logic rdy(input int which);
    return (which == 0) ? axi.awready : (which == 1) ? axi.arready : axi.wready;
  endfunction

  task automatic wait_rdy(input int which, input string name);
    int n = 0;
    do begin @(negedge aclk); n++; end while (!rdy(which) && n < 64);
    if (!rdy(which)) check({name, "_timeout"}, rdy(which), 1);
  endtask

  task automatic aw_start(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt);
    @(posedge aclk); #1;
    axi.awid = id; axi.awaddr = a; axi.awlen = len; axi.awburst = bt; axi.awvalid = 1'b1;
  endtask

  task automatic ar_start(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt);
    @(posedge aclk); #1;
    axi.arid = id; axi.araddr = a; axi.arlen = len; axi.arburst = bt; axi.arvalid = 1'b1;
  endtask

  task automatic aw_finish();
    wait_rdy(0, "awready");
    @(posedge aclk); #1; axi.awvalid = 1'b0;
  endtask

  task automatic ar_finish();
    wait_rdy(1, "arready");
    @(posedge aclk); #1; axi.arvalid = 1'b0;
  endtask

  task automatic w_beats(input int len, input int early);
    for (int i = 0; i <= len; i++) begin
      axi.wdata = wd[i]; axi.wstrb = ws[i];
      axi.wlast = (early >= 0) ? (i == early) : (i == len);
      axi.wvalid = 1'b1;
      wait_rdy(2, "wready");
      @(posedge aclk); #1;
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((bq.size() > 0 || rq.size() > 0) && n < 300) begin @(negedge aclk); n++; end
    if (n >= 300) check({name, "_drain_timeout"}, bq.size() + rq.size(), 0);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] bt, input int early, input logic [1:0] resp);
    bq.push_back('{id, resp});
    aw_start(id, a, len, bt);
    aw_finish();
    w_beats(int'(len), early);
    drain("write");
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] bt, input logic [1:0] resp);
    for (int i = 0; i <= int'(len); i++) rq.push_back('{id, ed[i], resp, (i == int'(len))});
    ar_start(id, a, len, bt);
    ar_finish();
    drain("read");
  endtask

  task automatic wait_any(input string name);
    int n = 0;
    do begin @(negedge aclk); n++; end while (!axi.awready && !axi.arready && n < 64);
    if (!axi.awready && !axi.arready) check({name, "_timeout"}, axi.awready | axi.arready, 1);
  endtask

  task automatic pulse_reset();
    @(posedge aclk); #1 areset = 1'b1;
    @(posedge aclk); #1 areset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awburst = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b1;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arburst = '0; axi.arvalid = 1'b0;
    for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 4'hF; ed[i] = '0; end
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready", axi.awready, 0);
    check("rst_arready", axi.arready, 0);
    check("rst_wready",  axi.wready, 0);
    check("rst_bvalid",  axi.bvalid, 0);
    check("rst_rvalid",  axi.rvalid, 0);
    check("rst_rlast",   axi.rlast, 0);
    check("rst_rdata",   axi.rdata, 0);
    check("rst_bid_rid", {axi.bid, axi.rid, axi.bresp, axi.rresp}, 0);
    @(posedge aclk); #1 areset = 1'b0;

    // full-word write / read with ID echo
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(4'd3, 32'h10, 8'd0, 2'd1, -1, 2'd0);
    ed[0] = 32'hDEADBEEF;
    do_read(4'd5, 32'h10, 8'd0, 2'd1, 2'd0);

    // byte strobes 0 and 2
    wd[0] = 32'h11223344; ws[0] = 4'h5;
    do_write(4'd4, 32'h10, 8'd0, 2'd1, -1, 2'd0);
    ed[0] = 32'hDE22BE44;
    do_read(4'd6, 32'h10, 8'd0, 2'd1, 2'd0);

    // INCR len 3, read back with rready alternating
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; ed[i] = 32'(i + 1); end
    do_write(4'd1, 32'h20, 8'd3, 2'd1, -1, 2'd0);
    rmode = 1;
    do_read(4'd2, 32'h20, 8'd3, 2'd1, 2'd0);
    rmode = 0;

    // WRAP len 3 from 0x38 wraps at 16-byte boundary 0x30
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    do_write(4'd2, 32'h38, 8'd3, 2'd2, -1, 2'd0);
    ed[0] = 32'hC; ed[1] = 32'hD; ed[2] = 32'hA; ed[3] = 32'hB;
    do_read(4'd3, 32'h30, 8'd3, 2'd1, 2'd0);
    ed[0] = 32'hA; ed[1] = 32'hB; ed[2] = 32'hC; ed[3] = 32'hD;
    do_read(4'd7, 32'h38, 8'd3, 2'd2, 2'd0);
    do_write(4'd4, 32'h40, 8'd2, 2'd2, -1, 2'd2);
    do_write(4'd5, 32'h44, 8'd0, 2'd3, -1, 2'd2);

    // arbitration: after reset write wins first collision, read wins the next
    pulse_reset();
    @(posedge aclk); #1;
    axi.awid = 4'd7; axi.awaddr = 32'h50; axi.awlen = 8'd0; axi.awburst = 2'd1; axi.awvalid = 1'b1;
    axi.arid = 4'd8; axi.araddr = 32'h10; axi.arlen = 8'd0; axi.arburst = 2'd1; axi.arvalid = 1'b1;
    wait_any("coll1");
    check("coll1_awready", axi.awready, 1);
    check("coll1_arready", axi.arready, 0);
    @(posedge aclk); #1; axi.awvalid = 1'b0; axi.arvalid = 1'b0;
    bq.push_back('{4'd7, 2'd0});
    wd[0] = 32'h55; ws[0] = 4'hF;
    w_beats(0, -1);
    drain("coll1");
    @(posedge aclk); #1;
    axi.awid = 4'd9;  axi.awaddr = 32'h54; axi.awlen = 8'd0; axi.awburst = 2'd1; axi.awvalid = 1'b1;
    axi.arid = 4'd10; axi.araddr = 32'h50; axi.arlen = 8'd0; axi.arburst = 2'd1; axi.arvalid = 1'b1;
    wait_any("coll2");
    check("coll2_arready", axi.arready, 1);
    check("coll2_awready", axi.awready, 0);
    rq.push_back('{4'd10, 32'h55, 2'd0, 1'b1});
    @(posedge aclk); #1; axi.arvalid = 1'b0;
    drain("coll2_rd");
    bq.push_back('{4'd9, 2'd0});
    aw_finish();
    wd[0] = 32'h66;
    w_beats(0, -1);
    drain("coll2_wr");
    ed[0] = 32'h66;
    do_read(4'd11, 32'h54, 8'd0, 2'd1, 2'd0);

    // out-of-range write must not alias onto word 0
    wd[0] = 32'h0BADF00D;
    do_write(4'd1, 32'h0, 8'd0, 2'd1, -1, 2'd0);
    wd[0] = 32'hCAFEBABE;
    do_write(4'd2, 32'h400, 8'd0, 2'd1, -1, 2'd2);
    ed[0] = 32'h0BADF00D;
    do_read(4'd3, 32'h0, 8'd0, 2'd1, 2'd0);
    ed[0] = 32'h0;
    do_read(4'd4, 32'h400, 8'd0, 2'd1, 2'd2);

    // early wlast on a two-beat burst
    wd[0] = 32'h77; wd[1] = 32'h88;
    do_write(4'd5, 32'h60, 8'd1, 2'd1, 0, 2'd2);

    // reset while a read is stalled
    rmode = 2;
    ar_start(4'd6, 32'h20, 8'd3, 2'd1);
    ar_finish();
    begin
      int n = 0;
      do begin @(negedge aclk); n++; end while (!axi.rvalid && n < 32);
      if (!axi.rvalid) check("stall_rvalid_timeout", axi.rvalid, 1);
    end
    pulse_reset();
    @(negedge aclk);
    check("midrst_rvalid", axi.rvalid, 0);
    check("midrst_rdata",  axi.rdata, 0);
    check("midrst_rlast",  axi.rlast, 0);
    check("midrst_ready",  {axi.awready, axi.arready, axi.wready}, 0);
    rmode = 0;
    for (int i = 0; i < 4; i++) ed[i] = 32'(i + 1);
    do_read(4'd7, 32'h20, 8'd3, 2'd1, 2'd0);
    ed[0] = 32'hDE22BE44;
    do_read(4'd8, 32'h10, 8'd0, 2'd1, 2'd0);

    repeat (4) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
